// File: rtl/flasher_pkg.sv
// flasher_pkg: shared types and constants for the flasher sequencer.
//   state_t         - sequencer FSM states (IDLE, UP, DN, FIN)
//   LVL_W           - width of the bar level register (0..16 fits in 5 bits)
//   LED_W           - width of the thermometer bar produced by lvl_to_therm
//   DEF_BOUND       - bound table loaded on reset
//   default_bound() - reset value for table entry i (0 beyond the default list)
//   lvl_to_therm()  - level -> thermometer bar, (1<<lvl)-1
package flasher_pkg;

  localparam int LVL_W     = 5;
  localparam int LED_W     = 16;
  localparam int DEF_NSTEP = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [LVL_W-1:0] DEF_BOUND [DEF_NSTEP] = '{
    5'd16, 5'd5, 5'd11, 5'd0, 5'd7, 5'd0
  };

  function automatic logic [LVL_W-1:0] default_bound(input int i);
    return (i < DEF_NSTEP) ? DEF_BOUND[i] : '0;
  endfunction

  function automatic logic [LED_W-1:0] lvl_to_therm(input logic [LVL_W-1:0] lvl);
    logic [LED_W-1:0] bar;
    for (int i = 0; i < LED_W; i++) begin
      bar[i] = (LVL_W'(i) < lvl);
    end
    return bar;
  endfunction

endpackage

// File: rtl/flasher_if.sv
// flasher_if: board-side control and LED bundle of the flasher sequencer.
//   start, flick          - launch / restart requests (level-sampled)
//   div                   - step period minus one
//   cfg_we/addr/bound     - bound-table write port (IDLE only)
//   pause                 - sequencing stall (only with FLASHER_PAUSE_EN)
//   LED, busy, done       - thermometer bar and run status
//   dbg_state, dbg_cnt    - FSM state and prescaler count for observation
// Modports: master drives the controls, slave is the sequencer.
// Optional feature macro: FLASHER_PAUSE_EN.
interface flasher_if #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 8
);
  import flasher_pkg::*;

  logic             start;
  logic             flick;
  logic [DIV_W-1:0] div;
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [4:0]       cfg_bound;
`ifdef FLASHER_PAUSE_EN
  logic             pause;
`endif
  logic [WIDTH-1:0] LED;
  logic             busy;
  logic             done;
  state_t           dbg_state;
  logic [DIV_W-1:0] dbg_cnt;

  modport master (
    output start, flick, div, cfg_we, cfg_addr, cfg_bound,
`ifdef FLASHER_PAUSE_EN
    output pause,
`endif
    input  LED, busy, done, dbg_state, dbg_cnt
  );

  modport slave (
    input  start, flick, div, cfg_we, cfg_addr, cfg_bound,
`ifdef FLASHER_PAUSE_EN
    input  pause,
`endif
    output LED, busy, done, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/flasher_prescaler.sv
// flasher_prescaler: step-tick generator.
//   clk, rst  - clock, synchronous active-high reset
//   clear     - force the count to zero (sequencer not stepping)
//   run       - advance the count this cycle (held when low)
//   div       - step period minus one; tick fires when cnt == div
//   tick      - one step this cycle
//   cnt       - current count
module flasher_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic [DIV_W-1:0] cnt
);

  // div is compared live, so a new divisor takes effect at the next compare.
  assign tick = run && (cnt == div);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/flasher_sequencer.sv
// flasher_sequencer: walks a 16-LED thermometer bar through a table of
// up/down bounds, one level per prescaled step tick.
//   clk  - clock
//   rst  - synchronous reset, active-high (also restores the bound table)
//   bus  - flasher_if.slave: start/flick/div/cfg_* in; LED/busy/done and
//          debug state/count out
// Optional feature macro: FLASHER_PAUSE_EN adds bus.pause, which freezes
// stepping while in UP/DN.
//
// Control handshake: start (or flick) is sampled while idle; busy rises the
// next cycle and stays high until the cycle in which done pulses for exactly
// one cycle. Requests seen while busy are dropped, not queued.
module flasher_sequencer
  import flasher_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NSTEP = 6,
  parameter int DIV_W = 8
) (
  input logic     clk,
  input logic     rst,
  flasher_if.slave bus
);

  localparam logic [LVL_W-1:0] MAX_LVL  = LVL_W'(WIDTH);
  localparam logic [2:0]       LAST_IDX = 3'(NSTEP - 1);

  state_t           state;
  logic [LVL_W-1:0] lvl;
  logic [2:0]       idx;
  logic [LVL_W-1:0] tbl [NSTEP];
  logic [WIDTH-1:0] led_q;
  logic             busy_q;
  logic             done_q;

  logic             tick;
  logic             stepping;
  logic             paused;
  logic [DIV_W-1:0] cnt;
  logic [LVL_W-1:0] cur_bound;
  logic [LVL_W-1:0] nxt_bound;
  logic [LVL_W-1:0] wr_bound;
  logic             last_step;
  state_t           adv_state;

`ifdef FLASHER_PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif

  assign stepping  = (state == UP) || (state == DN);
  assign last_step = (idx == LAST_IDX);
  assign cur_bound = tbl[idx];
  assign nxt_bound = last_step ? '0 : tbl[idx + 3'd1];
  // Direction of the next leg: equal bound counts as UP and is reached on
  // its first tick, giving another one-tick dwell.
  assign adv_state = (nxt_bound >= lvl) ? UP : DN;
  assign wr_bound  = (bus.cfg_bound > MAX_LVL) ? MAX_LVL : bus.cfg_bound;

  flasher_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (!stepping),
    .run   (stepping && !paused),
    .div   (bus.div),
    .tick  (tick),
    .cnt   (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lvl    <= '0;
      idx    <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < NSTEP; i++) begin
        tbl[i] <= default_bound(i);
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_we && (bus.cfg_addr <= LAST_IDX)) begin
            tbl[bus.cfg_addr] <= wr_bound;
          end
          if (bus.start || bus.flick) begin
            state  <= UP;
            idx    <= '0;
            busy_q <= 1'b1;
          end
        end
        UP: begin
          if (tick) begin
            if (lvl < cur_bound) begin
              lvl   <= lvl + 1'b1;
              led_q <= lvl_to_therm(lvl + 1'b1);
            end else if (last_step) begin
              state <= FIN;
            end else begin
              idx   <= idx + 3'd1;
              state <= adv_state;
            end
          end
        end
        DN: begin
          if (tick) begin
            if (lvl > cur_bound) begin
              lvl   <= lvl - 1'b1;
              led_q <= lvl_to_therm(lvl - 1'b1);
            end else if (bus.flick && !last_step) begin
              // Flick at a lower bound re-runs the previous rising leg.
              idx   <= (idx == 3'd0) ? 3'd0 : idx - 3'd1;
              state <= UP;
            end else if (last_step) begin
              state <= FIN;
            end else begin
              idx   <= idx + 3'd1;
              state <= adv_state;
            end
          end
        end
        FIN: begin
          done_q <= 1'b1;
          led_q  <= '0;
          lvl    <= '0;
          idx    <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.LED       = led_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state;
  assign bus.dbg_cnt   = cnt;

endmodule

// File: tb/tb_flasher_sequencer.sv
module tb_flasher_sequencer;
  import flasher_pkg::*;

  localparam int WIDTH = 16;
  localparam int NSTEP = 6;
  localparam int DIV_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flasher_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

  flasher_sequencer #(.WIDTH(WIDTH), .NSTEP(NSTEP), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  function automatic logic [WIDTH-1:0] therm(input int l);
    logic [31:0] t;
    t = (32'd1 << l) - 32'd1;
    return t[WIDTH-1:0];
  endfunction

  // Expected LED values for a leg from level a to level b (a excluded).
  task automatic add_ramp(input int a, input int b);
    if (a < b) begin
      for (int l = a + 1; l <= b; l++) exp_q.push_back(therm(l));
    end else begin
      for (int l = a - 1; l >= b; l--) exp_q.push_back(therm(l));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs;
    bus.start     = 1'b0;
    bus.flick     = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 3'd0;
    bus.cfg_bound = 5'd0;
`ifdef FLASHER_PAUSE_EN
    bus.pause     = 1'b0;
`endif
  endtask

  // Called at a negedge; returns at the negedge right after the launch edge.
  task automatic launch(input logic [DIV_W-1:0] d, input logic use_flick);
    bus.div = d;
    if (use_flick) bus.flick = 1'b1;
    else bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flick = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [4:0] b);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_bound = b;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    idle_inputs();
    bus.div = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.LED !== 16'h0000) begin bad++; $display("FAIL reset_led: got %h want 0000", bus.LED); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, IDLE); end
    total++; if (bus.dbg_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.dbg_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_div0;
    logic [WIDTH-1:0] prev, e;
    int n, done_at;
    exp_q.delete();
    add_ramp(0, 16); add_ramp(16, 5); add_ramp(5, 11);
    add_ramp(11, 0); add_ramp(0, 7); add_ramp(7, 0);
    launch('0, 1'b0);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL div0_busy_rise: got %b want 1", bus.busy); end
    prev = '0; done_at = -1; n = 0;
    while (done_at < 0 && n < 200) begin
      @(negedge clk); n++;
      bus.start = (n == 10);  // start while busy must be ignored
      if (bus.LED !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL div0_seq_extra: got %h at cycle %0d want no change", bus.LED, n);
        end else begin
          e = exp_q.pop_front();
          if (bus.LED !== e) begin bad++; $display("FAIL div0_seq: got %h want %h at cycle %0d", bus.LED, e, n); end
        end
        prev = bus.LED;
      end
      if (bus.done === 1'b1) done_at = n;
    end
    bus.start = 1'b0;
    total++; if (done_at != 65) begin bad++; $display("FAIL div0_done_cycle: got %0d want 65", done_at); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL div0_busy_fall: got %b want 0", bus.busy); end
    total++; if (bus.LED !== 16'h0000) begin bad++; $display("FAIL div0_led_end: got %h want 0000", bus.LED); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL div0_seq_short: got %0d left want 0", exp_q.size()); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL div0_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_div3;
    logic [WIDTH-1:0] prev;
    int n, done_at, nchg;
    launch(8'd3, 1'b0);
    prev = '0; done_at = -1; n = 0; nchg = 0;
    while (done_at < 0 && n < 400) begin
      @(negedge clk); n++;
      if (bus.LED !== prev) begin
        if (nchg < 16) begin
          total++;
          if (n != 4 * (nchg + 1)) begin bad++; $display("FAIL div3_spacing: change %0d got cycle %0d want %0d", nchg, n, 4 * (nchg + 1)); end
        end
        nchg++;
        prev = bus.LED;
      end
      if (bus.done === 1'b1) done_at = n;
    end
    total++; if (done_at != 257) begin bad++; $display("FAIL div3_done_cycle: got %0d want 257", done_at); end
    @(negedge clk);
  endtask

  task automatic test_flick;
    logic [WIDTH-1:0] prev, e;
    int n, done_at;
    exp_q.delete();
    add_ramp(0, 16); add_ramp(16, 5); add_ramp(5, 16); add_ramp(16, 5);
    add_ramp(5, 11); add_ramp(11, 0); add_ramp(0, 7); add_ramp(7, 0);
    launch('0, 1'b1);  // flick also launches from IDLE
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flick_launch: got %b want 1", bus.busy); end
    prev = '0; done_at = -1; n = 0;
    while (done_at < 0 && n < 200) begin
      @(negedge clk); n++;
      // Early flicks land in UP and must be ignored; the one at cycle 28 hits
      // the DN tick at bound 5 (idx 1).
      bus.flick = (n == 28) || (n >= 2 && n <= 4);
      if (n == 28) begin
        total++; if (bus.LED !== 16'h001F) begin bad++; $display("FAIL flick_at_bound: got %h want 001f", bus.LED); end
      end
      if (bus.LED !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL flick_seq_extra: got %h at cycle %0d want no change", bus.LED, n);
        end else begin
          e = exp_q.pop_front();
          if (bus.LED !== e) begin bad++; $display("FAIL flick_seq: got %h want %h at cycle %0d", bus.LED, e, n); end
        end
        prev = bus.LED;
      end
      if (bus.done === 1'b1) done_at = n;
    end
    bus.flick = 1'b0;
    total++; if (done_at != 89) begin bad++; $display("FAIL flick_done_cycle: got %0d want 89", done_at); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL flick_seq_short: got %0d left want 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_config;
    logic [WIDTH-1:0] prev, e;
    int n, done_at;
    cfg_write(3'd1, 5'd9);
    cfg_write(3'd5, 5'd31);  // clamps to 16
    cfg_write(3'd0, 5'd20);  // clamps to 16
    cfg_write(3'd6, 5'd2);   // out of range, ignored
    cfg_write(3'd7, 5'd3);   // out of range, ignored
    exp_q.delete();
    add_ramp(0, 16); add_ramp(16, 9); add_ramp(9, 11);
    add_ramp(11, 0); add_ramp(0, 7); add_ramp(7, 16);
    exp_q.push_back(16'h0000);  // FIN clears the bar
    launch('0, 1'b0);
    prev = '0; done_at = -1; n = 0;
    while (done_at < 0 && n < 200) begin
      @(negedge clk); n++;
      // Write while busy must be dropped.
      bus.cfg_we    = (n == 3);
      bus.cfg_addr  = 3'd2;
      bus.cfg_bound = 5'd1;
      if (bus.LED !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL cfg_seq_extra: got %h at cycle %0d want no change", bus.LED, n);
        end else begin
          e = exp_q.pop_front();
          if (bus.LED !== e) begin bad++; $display("FAIL cfg_seq: got %h want %h at cycle %0d", bus.LED, e, n); end
        end
        prev = bus.LED;
      end
      if (bus.done === 1'b1) done_at = n;
    end
    bus.cfg_we = 1'b0;
    total++; if (done_at != 59) begin bad++; $display("FAIL cfg_done_cycle: got %0d want 59", done_at); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cfg_seq_short: got %0d left want 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n, done_at;
    launch('0, 1'b0);
    n = 0;
    while (bus.LED !== 16'h00FF && n < 40) begin
      @(negedge clk); n++;
    end
    total++; if (n != 8) begin bad++; $display("FAIL rstmid_reach: got cycle %0d want 8", n); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.LED !== 16'h0000) begin bad++; $display("FAIL rstmid_led: got %h want 0000", bus.LED); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    total++; if (bus.dbg_state !== IDLE) begin bad++; $display("FAIL rstmid_state: got %0d want %0d", bus.dbg_state, IDLE); end
    rst = 1'b0;
    @(negedge clk);
    // Default table restored: full default run length again.
    launch('0, 1'b0);
    done_at = -1; n = 0;
    while (done_at < 0 && n < 200) begin
      @(negedge clk); n++;
      if (bus.done === 1'b1) done_at = n;
    end
    total++; if (done_at != 65) begin bad++; $display("FAIL rstmid_table_default: got %0d want 65", done_at); end
    @(negedge clk);
  endtask

`ifdef FLASHER_PAUSE_EN
  task automatic test_pause;
    int n, done_at;
    launch(8'd3, 1'b0);
    n = 0;
    while (bus.LED !== 16'h003F && n < 100) begin
      @(negedge clk); n++;
    end
    total++; if (n != 24) begin bad++; $display("FAIL pause_reach: got cycle %0d want 24", n); end
    @(negedge clk); n++;
    total++; if (bus.dbg_cnt !== 8'd1) begin bad++; $display("FAIL pause_cnt_pre: got %0d want 1", bus.dbg_cnt); end
    bus.pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); n++;
      total++;
      if ({bus.LED, bus.busy, bus.dbg_cnt} !== {16'h003F, 1'b1, 8'd1}) begin
        bad++; $display("FAIL pause_hold: got led=%h busy=%b cnt=%0d want led=003f busy=1 cnt=1", bus.LED, bus.busy, bus.dbg_cnt);
      end
    end
    bus.pause = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.LED !== 16'h003F) begin bad++; $display("FAIL pause_resume_early: got %h want 003f", bus.LED); end
    @(negedge clk);
    total++; if (bus.LED !== 16'h007F) begin bad++; $display("FAIL pause_resume: got %h want 007f", bus.LED); end
    n = 38; done_at = -1;
    while (done_at < 0 && n < 400) begin
      @(negedge clk); n++;
      if (bus.done === 1'b1) done_at = n;
    end
    total++; if (done_at != 267) begin bad++; $display("FAIL pause_done_cycle: got %0d want 267", done_at); end
    @(negedge clk);
  endtask
`endif

  // ---------------- main sequence / report ----------------
  initial begin
    rst = 1'b1;
    bus.div = '0;
    idle_inputs();
    test_reset();
    test_full_div0();
    test_div3();
    test_flick();
    test_config();
    test_reset_mid();
`ifdef FLASHER_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flasher_sequencer.md
Name: flasher_sequencer

Overview:
- Programmable controller that sequences a 16-LED thermometer bar through a list of up/down bounds, paced by a prescaled step tick.
- Holds the bound table (writable config port), the step index, the direction FSM and the LED datapath register.
- Handles flick-restart, start/busy/done signalling and table reconfiguration.
- Sits between the board-level control inputs (start, flick, config writes) and the LED pins.

Parameters:
- WIDTH, 16, number of LEDs; level range 0..WIDTH.
- NSTEP, 6, number of bound-table entries (steps).
- DIV_W, 8, prescaler divisor width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  level-sampled; launches a sequence when idle
- flick  in  1  restart request (see Behaviour)
- div  in  DIV_W  step period minus 1; one step every div+1 cycles
- cfg_we  in  1  bound-table write enable
- cfg_addr  in  3  table index, 0..NSTEP-1
- cfg_bound  in  5  target level for that step
- LED  out  WIDTH  thermometer output, LED = (1<<lvl)-1
- busy  out  1  sequence running
- done  out  1  one-cycle pulse on sequence completion

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - LED=0, lvl=0, idx=0, state=IDLE, busy=0, done=0, prescaler cnt=0.
  - Bound table = {16,5,11,0,7,0} for idx 0..5.
- Reset asserted mid-sequence aborts it: next cycle LED=0 and the table returns to defaults.
- Registered state: lvl[4:0], idx[2:0], cnt[DIV_W-1:0], state in {IDLE, UP, DN, FIN}. LED, busy and done are registered outputs.
- Tick: cnt increments each cycle while state is UP or DN; tick=1 when cnt==div, then cnt<=0. With div=0, tick is every cycle. cnt is held at 0 in IDLE and FIN.
- IDLE:
  - start=1 or flick=1 -> next cycle state=UP, idx=0, cnt=0, busy=1, lvl unchanged (0).
  - First LED change occurs div+1 cycles after entry.
- UP, on tick:
  - If lvl<bound[idx]: lvl<=lvl+1.
  - Otherwise (reached): if idx==NSTEP-1, go to FIN. Else idx<=idx+1 and state <= (bound[idx+1]>=lvl) ? UP : DN. lvl holds, giving a one-tick dwell at each bound.
- DN, on tick:
  - If lvl>bound[idx]: lvl<=lvl-1.
  - Otherwise (reached): flick=1 and idx!=NSTEP-1 -> idx<=idx-1 (saturating at 0), state=UP, lvl holds.
  - Reached without that flick case: same advance rule as UP.
- flick is ignored outside IDLE and outside the DN-at-bound tick.
- FIN (one cycle): done=1, LED<=0, lvl<=0, idx<=0, busy<=0 -> IDLE.
- Config writes:
  - Honoured only in IDLE; dropped silently when busy.
  - cfg_bound>WIDTH is clamped to WIDTH.
  - cfg_addr>=NSTEP is ignored.
- start while busy: ignored; no queueing.
- div may change at any time; the new value applies from the next compare.
- Arithmetic: lvl never leaves 0..WIDTH; decrement at 0 and increment at WIDTH cannot occur because the reach check comes first.

Optional Feature:
- FLASHER_PAUSE_EN
- Defined: adds input port pause (1 bit). While pause=1 in UP/DN, cnt, lvl, idx and state all freeze and start/flick are ignored; pause has no effect in IDLE/FIN.
- Undefined: no pause port; sequencing is never stalled.

Decomposition:
- Package flasher_pkg:
  - State enum: IDLE, UP, DN, FIN.
  - Default bound table constant: {16,5,11,0,7,0}.
  - LVL_W=5.
  - Function lvl_to_therm(lvl) returning the WIDTH-bit bar.
- One natural sub-module: flasher_prescaler (cnt, div compare, tick, clear and hold controls).

Test Plan:
- Reset then start, div=0: LED ramps 0x0001..0xFFFF one bit per cycle, dwells one tick, falls to 0x001F, then up to 0x07FF, down to 0, up to 0x007F, down to 0. done pulses once, busy drops the same cycle, LED=0.
- div=3: each LED change is spaced exactly 4 cycles; the first change occurs 4 cycles after busy rises.
- flick=1 at the DN tick where lvl==5 (idx=1): idx returns to 0, state UP. LED climbs to 0xFFFF again, then the sequence continues normally.
- Config in IDLE: write bound[0]=20 -> stored as 16. Write while busy is dropped (read back via behaviour: sequence unchanged).
- rst pulsed mid-ramp at LED=0x00FF: next cycle LED=0, busy=0, and a previously modified table reverts to defaults.
- With FLASHER_PAUSE_EN defined: pause for 10 cycles at LED=0x003F -> LED, busy and cnt hold for those 10 cycles, and the sequence then resumes with the remaining tick count preserved.
